// File: rtl/dma_pkg.sv
// ==== dma_pkg : shared types and widths for the CPU-to-bus DMA block ====
// ==== Rev 1.0 ====
`default_nettype none

package dma_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ERR  = 2'd3
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dma_entry_t;

endpackage

`default_nettype wire

// File: rtl/cpu_bus_dma_if.sv
// ==== cpu_bus_dma_if : CPU posting side plus system-bus handshake ====
// ==== Rev 1.0 ====
`default_nettype none

interface cpu_bus_dma_if;
  import dma_pkg::*;

  logic              en;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataOut;
  logic              halt;
  logic              ack;
  logic              nextTransaction;
  logic [1:0]        Interrupt;
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_wr;
  logic              bus_ack;

  modport slave (
    input  en, memAddr, memDataOut, halt, ack, bus_gnt, bus_ack,
    output nextTransaction, Interrupt, bus_req, bus_addr, bus_data, bus_wr
  );

  modport master (
    output en, memAddr, memDataOut, halt, ack, bus_gnt, bus_ack,
    input  nextTransaction, Interrupt, bus_req, bus_addr, bus_data, bus_wr
  );

endinterface

`default_nettype wire

// File: rtl/dma_fifo.sv
// ==== dma_fifo : synchronous entry FIFO, power-of-2 depth, async reset ====
// ==== Rev 1.0 ====
`default_nettype none

module dma_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  dma_entry_t             din_i,
  input  logic                   pop_i,
  output dma_entry_t             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dma_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cpu_bus_dma.sv
// ==== cpu_bus_dma : replays CPU-posted writes onto a req/gnt/ack bus ====
// ==== Rev 1.0 ====
`default_nettype none

module cpu_bus_dma
  import dma_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  cpu_bus_dma_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_XFER = XFER;
  localparam logic [1:0] S_ERR  = ERR;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    irq_q, irq_d;
  logic          drained_q, drained_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push, pop, drop, set_drain, xfer;
  dma_entry_t    wr_entry, head;

  assign wr_entry = {bus.memAddr, bus.memDataOut};
  assign push     = bus.en && !fifo_full;
  assign drop     = bus.en && fifo_full;
  assign pop      = (state_q == S_XFER && bus.bus_ack) || (state_q == S_ERR);
  assign xfer     = (state_q == S_XFER);

  dma_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_REQ;
      S_REQ: begin
        if (bus.bus_gnt) begin
          state_d = S_XFER;
          timer_d = '0;
        end
      end
      S_XFER: begin
        if (bus.bus_ack)                        state_d = (fifo_count > CW'(1)) ? S_REQ : S_IDLE;
        else if (timer_q == TW'(TIMEOUT - 1))   state_d = S_ERR;
        else                                    timer_d = timer_q + 1'b1;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // drained_q blocks a second drain interrupt until halt has been released once.
  assign set_drain = bus.halt && fifo_empty && (state_q == S_IDLE) && !irq_q[0] && !drained_q;

  always_comb begin
    irq_d = irq_q;
    if (bus.ack)                       irq_d    = 2'b00;
    if (set_drain)                     irq_d[0] = 1'b1;
    if (drop || (state_q == S_ERR))    irq_d[1] = 1'b1;
    drained_d = drained_q;
    if (!bus.halt)      drained_d = 1'b0;
    else if (set_drain) drained_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      irq_q     <= 2'b00;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
      drained_q <= drained_d;
    end
  end

  assign bus.nextTransaction = !fifo_full;
  assign bus.Interrupt       = irq_q;
  assign bus.bus_req         = (state_q == S_REQ) || xfer;
  assign bus.bus_wr          = xfer;
  assign bus.bus_addr        = xfer ? head.addr : '0;
  assign bus.bus_data        = xfer ? head.data : '0;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_dma.sv
// ==== tb_cpu_bus_dma : scoreboard bench for cpu_bus_dma ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_cpu_bus_dma;
  import dma_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_bus_dma_if bif ();

  cpu_bus_dma #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  dma_entry_t exp_q[$];
  dma_entry_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queue: an entry is accepted iff fewer than DEPTH are outstanding.
  task automatic post(input logic [31:0] a, input logic [31:0] d);
    dma_entry_t ent;
    check("nextTransaction", 64'(bif.nextTransaction), 64'(exp_q.size() < DEPTH));
    bif.en         = 1'b1;
    bif.memAddr    = a;
    bif.memDataOut = d;
    ent.addr = a;
    ent.data = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(ent);
    tick();
    bif.en = 1'b0;
  endtask

  task automatic wait_bus_wr(input int max_cycles);
    int k = 0;
    while (!bif.bus_wr && k < max_cycles) begin
      tick();
      k++;
    end
    check("wait_xfer", 64'(bif.bus_wr), 64'd1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      tick();
      k++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  // Monitor: every completed beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.bus_wr && bif.bus_ack) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", bif.bus_addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_addr", 64'(bif.bus_addr), 64'(mon_e.addr));
          check("beat_data", 64'(bif.bus_data), 64'(mon_e.data));
        end
      end else if (!bif.bus_wr) begin
        check("bus_zero_outside_xfer", {bif.bus_addr, bif.bus_data}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bif.en = 0; bif.memAddr = '0; bif.memDataOut = '0; bif.halt = 0; bif.ack = 0;
    bif.bus_gnt = 0; bif.bus_ack = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_nextTransaction", 64'(bif.nextTransaction), 64'd1);
    check("rst_Interrupt",       64'(bif.Interrupt),       64'd0);
    check("rst_bus_req",         64'(bif.bus_req),         64'd0);
    check("rst_bus_wr",          64'(bif.bus_wr),          64'd0);
    check("rst_bus_addr",        64'(bif.bus_addr),        64'd0);
    check("rst_bus_data",        64'(bif.bus_data),        64'd0);

    // Single post with grant and ack tied high
    bif.bus_gnt = 1; bif.bus_ack = 1;
    post(32'h100, 32'hDEADBEEF);
    check("single_req_at_accept", 64'(bif.bus_req), 64'd0);
    tick();
    check("single_req_after_E1", 64'(bif.bus_req), 64'd1);
    check("single_wr_in_req",    64'(bif.bus_wr),  64'd0);
    tick();
    check("single_wr",   64'(bif.bus_wr),   64'd1);
    check("single_addr", 64'(bif.bus_addr), 64'h100);
    check("single_data", 64'(bif.bus_data), 64'hDEADBEEF);
    tick();
    check("single_wr_done",  64'(bif.bus_wr),  64'd0);
    check("single_req_done", 64'(bif.bus_req), 64'd0);

    // Fill to full, overflow drop, then release the bus
    bif.bus_gnt = 0; bif.bus_ack = 0;
    for (int i = 0; i < DEPTH; i++) post(32'h200 + 32'(i * 4), $urandom);
    check("fill_full", 64'(bif.nextTransaction), 64'd0);
    post(32'h2FF0, 32'h0BADF00D);
    check("fill_drop_irq", 64'(bif.Interrupt), 64'd2);
    check("fill_req_wait", 64'(bif.bus_req),   64'd1);
    bif.ack = 1; tick(); bif.ack = 0;
    check("fill_ack_clear", 64'(bif.Interrupt), 64'd0);
    bif.bus_gnt = 1; bif.bus_ack = 1;
    wait_drain(40);

    // Timeout: granted but never acked
    bif.bus_gnt = 1; bif.bus_ack = 0;
    post(32'h300, 32'h11111111);
    post(32'h304, 32'h22222222);
    wait_bus_wr(10);
    n = 0;
    while (bif.bus_wr && n < 200) begin
      n++;
      tick();
    end
    check("timeout_cycles",  64'(n),             64'(TIMEOUT));
    check("err_bus_req",     64'(bif.bus_req),   64'd0);
    check("err_irq_pending", 64'(bif.Interrupt), 64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    bif.bus_ack = 1;
    tick();
    check("timeout_irq", 64'(bif.Interrupt), 64'd2);
    bif.ack = 1; tick(); bif.ack = 0;
    check("timeout_ack_clear", 64'(bif.Interrupt), 64'd0);
    wait_drain(20);

    // Drain interrupt after halt
    bif.bus_gnt = 1; bif.bus_ack = 1;
    post(32'h400, 32'hA0A0A0A0);
    post(32'h404, 32'hB0B0B0B0);
    bif.halt = 1;
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      tick();
      n++;
      if (bif.Interrupt[0]) seen = 1;
    end
    check("drain_irq_seen",       64'(seen),          64'd1);
    check("drain_after_beats",    64'(exp_q.size()),  64'd0);
    check("drain_irq_value",      64'(bif.Interrupt), 64'd1);
    bif.ack = 1; tick(); bif.ack = 0;
    check("drain_ack_clear", 64'(bif.Interrupt), 64'd0);
    repeat (4) tick();
    check("drain_no_rearm", 64'(bif.Interrupt), 64'd0);
    bif.halt = 0; tick();
    bif.halt = 1; bif.ack = 1; tick();
    check("drain_set_beats_ack", 64'(bif.Interrupt), 64'd1);
    tick();
    check("drain_ack_after_set", 64'(bif.Interrupt), 64'd0);
    bif.ack = 0; bif.halt = 0; tick();

    // Asynchronous reset in the middle of a transfer
    bif.bus_gnt = 1; bif.bus_ack = 0;
    post(32'h500, 32'h55555555);
    post(32'h504, 32'h66666666);
    wait_bus_wr(10);
    rst = 1'b1;
    #1;
    check("async_rst_req", 64'(bif.bus_req), 64'd0);
    check("async_rst_wr",  64'(bif.bus_wr),  64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("post_rst_next", 64'(bif.nextTransaction), 64'd1);
    check("post_rst_irq",  64'(bif.Interrupt),       64'd0);
    bif.bus_ack = 1;
    repeat (3) tick();
    check("post_rst_flushed", 64'(bif.bus_req), 64'd0);

    // Simultaneous push and pop at two outstanding entries
    bif.bus_gnt = 0; bif.bus_ack = 1;
    post(32'h600, 32'h60000000);
    post(32'h604, 32'h60000004);
    bif.bus_gnt = 1;
    tick();
    post(32'h608, 32'h60000008);
    bif.bus_gnt = 0;
    check("pushpop_back_to_req", 64'(bif.bus_req), 64'd1);
    post(32'h60C, 32'h6000000C);
    post(32'h610, 32'h60000010);
    post(32'h614, 32'h60000014);
    check("pushpop_count_irq", 64'(bif.Interrupt), 64'd2);
    bif.ack = 1; tick(); bif.ack = 0;
    bif.bus_gnt = 1;
    wait_drain(40);

    // Randomised traffic with a random bus
    bif.ack = 1;
    for (int c = 0; c < 300; c++) begin
      bif.bus_gnt = ($urandom_range(0, 3) != 0);
      bif.bus_ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) post($urandom, $urandom);
      else tick();
    end
    bif.bus_gnt = 1; bif.bus_ack = 1;
    wait_drain(60);
    check("random_irq_clear", 64'(bif.Interrupt), 64'd0);
    check("random_idle_req",  64'(bif.bus_req),   64'd0);
    bif.ack = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
